// File: rtl/known_ch_pkg.sv
// -----------------------------------------------------------------------------
// known_ch_pkg
// Shared definitions for the known-cluster-head tracker:
//   DEF_WORD_WIDTH - default width of ID / hops / Q-value fields
//   DEF_KCH_DEPTH  - default number of known-cluster-head table entries
//   HOPS_INVALID   - hop count meaning "unreachable" (default width)
//   kch_entry_t    - one table entry {valid, id, hops, q} at default width
//   hops_reachable - true when a hop count is not the unreachable marker
// -----------------------------------------------------------------------------
package known_ch_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_KCH_DEPTH  = 8;

    localparam logic [DEF_WORD_WIDTH-1:0] HOPS_INVALID = 16'hFFFF;

    typedef struct packed {
        logic                      valid;
        logic [DEF_WORD_WIDTH-1:0] id;
        logic [DEF_WORD_WIDTH-1:0] hops;
        logic [DEF_WORD_WIDTH-1:0] q;
    } kch_entry_t;

    function automatic logic hops_reachable(input logic [DEF_WORD_WIDTH-1:0] hops);
        return (hops != HOPS_INVALID);
    endfunction

endpackage

// File: rtl/known_ch_v3_best_select.sv
// -----------------------------------------------------------------------------
// kch_best_select
// Combinational best-entry selector over the known-cluster-head table.
// Ranking: lowest hops first; on equal hops the higher Q wins; on equal hops
// and Q the higher table index (later arrival) wins.
// Ports:
//   valid      [DEPTH]      per-entry valid bits
//   id/hops/q  [DEPTH][W]   per-entry fields
//   best_valid              at least one valid entry exists
//   best_id, best_hops      fields of the winning entry (0 when none valid)
// -----------------------------------------------------------------------------
module kch_best_select #(
    parameter int WORD_WIDTH = 16,
    parameter int KCH_DEPTH  = 8
) (
    input  logic [KCH_DEPTH-1:0]  valid,
    input  logic [WORD_WIDTH-1:0] id   [KCH_DEPTH],
    input  logic [WORD_WIDTH-1:0] hops [KCH_DEPTH],
    input  logic [WORD_WIDTH-1:0] q    [KCH_DEPTH],
    output logic                  best_valid,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_hops
);

    logic [WORD_WIDTH-1:0] best_q_s;
    logic                  take_s;

    // Linear scan from index 0 upward; ">=" on Q lets a later index win a full tie.
    always_comb begin
        best_valid = 1'b0;
        best_id    = {WORD_WIDTH{1'b0}};
        best_hops  = {WORD_WIDTH{1'b0}};
        best_q_s   = {WORD_WIDTH{1'b0}};
        take_s     = 1'b0;
        for (int i = 0; i < KCH_DEPTH; i++) begin
            take_s = valid[i] &&
                     (!best_valid ||
                      (hops[i] < best_hops) ||
                      ((hops[i] == best_hops) && (q[i] >= best_q_s)));
            best_id    = take_s ? id[i]   : best_id;
            best_hops  = take_s ? hops[i] : best_hops;
            best_q_s   = take_s ? q[i]    : best_q_s;
            best_valid = best_valid | take_s;
        end
    end

endmodule

// File: rtl/known_ch_v3.sv
// -----------------------------------------------------------------------------
// known_ch_v3
// Tracks advertised cluster heads in a small table and registers the best one.
// Ports:
//   clk         clock, all state on the rising edge
//   nrst        asynchronous reset, active high (asserted = 1)
//   en_KCH      one-cycle strobe: fCH_* hold a cluster-head advertisement
//   HB_reset    heartbeat: clears the table and forces outputs to "none"
//   fCH_ID      advertised cluster-head ID
//   fCH_Hops    hop count to that head, all-ones = unreachable
//   fCH_QValue  unsigned Q2.14 quality value
//   chosenCH    registered ID of the selected head (0 when none)
//   hopsFromCH  registered hop count of the selected head (all-ones when none)
// -----------------------------------------------------------------------------
module known_ch_v3
    import known_ch_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int KCH_DEPTH  = DEF_KCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsFromCH
);

    localparam int IDX_W = (KCH_DEPTH > 1) ? $clog2(KCH_DEPTH) : 1;
    localparam logic [WORD_WIDTH-1:0] HOPS_NONE = {WORD_WIDTH{1'b1}};
    localparam logic [WORD_WIDTH-1:0] ID_NONE   = {WORD_WIDTH{1'b0}};

    logic [KCH_DEPTH-1:0]  valid_r;
    logic [WORD_WIDTH-1:0] id_r   [KCH_DEPTH];
    logic [WORD_WIDTH-1:0] hops_r [KCH_DEPTH];
    logic [WORD_WIDTH-1:0] q_r    [KCH_DEPTH];

    logic                  match_hit_s;
    logic [IDX_W-1:0]      match_idx_s;
    logic                  free_hit_s;
    logic [IDX_W-1:0]      free_idx_s;
    logic                  write_en_s;
    logic [IDX_W-1:0]      write_idx_s;

    logic                  best_valid_s;
    logic [WORD_WIDTH-1:0] best_id_s;
    logic [WORD_WIDTH-1:0] best_hops_s;

    // Find a valid entry with the advertised ID and the lowest free slot.
    // Scanning downward leaves the lowest free index as the final answer.
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = {IDX_W{1'b0}};
        free_hit_s  = 1'b0;
        free_idx_s  = {IDX_W{1'b0}};
        for (int i = KCH_DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && (id_r[i] == fCH_ID)) begin
                match_hit_s = 1'b1;
                match_idx_s = IDX_W'(i);
            end else if (!valid_r[i]) begin
                free_hit_s = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_hit_s = free_hit_s;
            end
        end
    end

    // Decide whether this advertisement lands in the table and where.
    // Unreachable advertisements never touch the table, not even to update.
    always_comb begin
        write_en_s  = en_KCH && !HB_reset && (fCH_Hops != HOPS_NONE) &&
                      (match_hit_s || free_hit_s);
        write_idx_s = match_hit_s ? match_idx_s : free_idx_s;
    end

    // Table storage: async clear, heartbeat drops all entries, otherwise write.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            valid_r <= {KCH_DEPTH{1'b0}};
            for (int i = 0; i < KCH_DEPTH; i++) begin
                id_r[i]   <= {WORD_WIDTH{1'b0}};
                hops_r[i] <= {WORD_WIDTH{1'b0}};
                q_r[i]    <= {WORD_WIDTH{1'b0}};
            end
        end else if (HB_reset) begin
            valid_r <= {KCH_DEPTH{1'b0}};
        end else if (write_en_s) begin
            valid_r[write_idx_s] <= 1'b1;
            id_r[write_idx_s]    <= fCH_ID;
            hops_r[write_idx_s]  <= fCH_Hops;
            q_r[write_idx_s]     <= fCH_QValue;
        end else begin
            valid_r <= valid_r;
        end
    end

    kch_best_select #(
        .WORD_WIDTH (WORD_WIDTH),
        .KCH_DEPTH  (KCH_DEPTH)
    ) u_best (
        .valid      (valid_r),
        .id         (id_r),
        .hops       (hops_r),
        .q          (q_r),
        .best_valid (best_valid_s),
        .best_id    (best_id_s),
        .best_hops  (best_hops_s)
    );

    // Output registers follow the selector every cycle; heartbeat forces "none".
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            chosenCH   <= ID_NONE;
            hopsFromCH <= HOPS_NONE;
        end else if (HB_reset || !best_valid_s) begin
            chosenCH   <= ID_NONE;
            hopsFromCH <= HOPS_NONE;
        end else begin
            chosenCH   <= best_id_s;
            hopsFromCH <= best_hops_s;
        end
    end

endmodule

// File: tb/tb_known_ch_v3.sv
// -----------------------------------------------------------------------------
// tb_known_ch_v3
// Directed stimulus against known_ch_v3 with a behavioural table model and
// literal checkpoints on the selected cluster head.
// -----------------------------------------------------------------------------
module tb_known_ch_v3;
    import known_ch_pkg::*;

    localparam int W = DEF_WORD_WIDTH;
    localparam int D = DEF_KCH_DEPTH;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en_KCH;
    logic         HB_reset;
    logic [W-1:0] fCH_ID;
    logic [W-1:0] fCH_Hops;
    logic [W-1:0] fCH_QValue;
    logic [W-1:0] chosenCH;
    logic [W-1:0] hopsFromCH;

    int n_vec = 0;
    int n_err = 0;

    // Model state: entries in arrival order, plus expected registered outputs.
    kch_entry_t   m_tab [D];
    int           m_cnt;
    logic [W-1:0] exp_ch;
    logic [W-1:0] exp_hops;

    known_ch_v3 dut (
        .clk        (clk),
        .nrst       (nrst),
        .en_KCH     (en_KCH),
        .HB_reset   (HB_reset),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .chosenCH   (chosenCH),
        .hopsFromCH (hopsFromCH)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < D; i++) m_tab[i] = '0;
        m_cnt    = 0;
        exp_ch   = 16'h0000;
        exp_hops = 16'hFFFF;
    endtask

    // Best = minimum hops, then maximum Q among those, then latest arrival.
    task automatic model_best(output logic [W-1:0] ch, output logic [W-1:0] hp);
        int min_h;
        int max_q;
        ch    = 16'h0000;
        hp    = 16'hFFFF;
        min_h = 32'h7FFF_FFFF;
        max_q = -1;
        for (int i = 0; i < m_cnt; i++)
            if (int'(m_tab[i].hops) < min_h) min_h = int'(m_tab[i].hops);
        for (int i = 0; i < m_cnt; i++)
            if (int'(m_tab[i].hops) == min_h && int'(m_tab[i].q) > max_q) max_q = int'(m_tab[i].q);
        for (int i = 0; i < m_cnt; i++)
            if (int'(m_tab[i].hops) == min_h && int'(m_tab[i].q) == max_q) begin
                ch = m_tab[i].id;
                hp = m_tab[i].hops;
            end
    endtask

    // Apply one clock edge to the model using the inputs the DUT just sampled.
    task automatic model_edge();
        int hit;
        if (HB_reset) begin
            model_clear();
        end else begin
            model_best(exp_ch, exp_hops);
            if (en_KCH && fCH_Hops != 16'hFFFF) begin
                hit = -1;
                for (int i = 0; i < m_cnt; i++)
                    if (m_tab[i].id == fCH_ID) hit = i;
                if (hit >= 0) begin
                    m_tab[hit].hops = fCH_Hops;
                    m_tab[hit].q    = fCH_QValue;
                end else if (m_cnt < D) begin
                    m_tab[m_cnt] = '{valid: 1'b1, id: fCH_ID, hops: fCH_Hops, q: fCH_QValue};
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic compare(input string name);
        n_vec++;
        if (chosenCH !== exp_ch || hopsFromCH !== exp_hops) begin
            n_err++;
            $display("FAIL %s: got chosenCH=%h hopsFromCH=%h, expected %h/%h",
                     name, chosenCH, hopsFromCH, exp_ch, exp_hops);
        end
    endtask

    // Hand-computed checkpoint: pins both the DUT and the model.
    task automatic check_lit(input string name, input logic [W-1:0] ch, input logic [W-1:0] hp);
        n_vec++;
        if (chosenCH !== ch || hopsFromCH !== hp) begin
            n_err++;
            $display("FAIL %s: got chosenCH=%h hopsFromCH=%h, expected %h/%h",
                     name, chosenCH, hopsFromCH, ch, hp);
        end
        n_vec++;
        if (exp_ch !== ch || exp_hops !== hp) begin
            n_err++;
            $display("FAIL %s_model: model gives %h/%h, expected %h/%h",
                     name, exp_ch, exp_hops, ch, hp);
        end
    endtask

    task automatic step(input logic e, input logic h, input logic [W-1:0] id,
                        input logic [W-1:0] hp, input logic [W-1:0] qv, input string name);
        en_KCH     = e;
        HB_reset   = h;
        fCH_ID     = id;
        fCH_Hops   = hp;
        fCH_QValue = qv;
        @(posedge clk);
        model_edge();
        #1;
        compare(name);
    endtask

    task automatic adv(input logic [W-1:0] id, input logic [W-1:0] hp, input logic [W-1:0] qv);
        step(1'b1, 1'b0, id, hp, qv, "adv");
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "adv_settle");
    endtask

    initial begin
        nrst       = 1'b1;
        en_KCH     = 1'b0;
        HB_reset   = 1'b0;
        fCH_ID     = 16'h0000;
        fCH_Hops   = 16'h0000;
        fCH_QValue = 16'h0000;
        model_clear();
        #1;
        check_lit("reset", 16'h0000, 16'hFFFF);
        #2;
        nrst = 1'b0;

        step(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, "hb");
        check_lit("hb_pulse", 16'h0000, 16'hFFFF);

        // First advertisement appears only after the second edge.
        step(1'b1, 1'b0, 16'd23, 16'd2, 16'h3000, "adv23");
        check_lit("latency_one_edge", 16'h0000, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "adv23_settle");
        check_lit("first_ch", 16'd23, 16'd2);

        adv(16'd45, 16'd2, 16'h2000);
        check_lit("lower_q_loses", 16'd23, 16'd2);
        adv(16'd6, 16'd1, 16'h4000);
        check_lit("fewer_hops", 16'd6, 16'd1);
        adv(16'd7, 16'd1, 16'h4000);
        check_lit("tie_later_wins", 16'd7, 16'd1);
        adv(16'd65, 16'd1, 16'h6000);
        check_lit("higher_q", 16'd65, 16'd1);
        adv(16'd65, 16'd3, 16'h6000);
        check_lit("update_in_place", 16'd7, 16'd1);

        // Five entries used; three more fill the table exactly.
        adv(16'd100, 16'd5, 16'h1000);
        adv(16'd101, 16'd4, 16'h1000);
        adv(16'd102, 16'd0, 16'h1000);
        check_lit("eighth_entry", 16'd102, 16'd0);
        adv(16'd103, 16'd0, 16'h7000);
        check_lit("full_drop", 16'd102, 16'd0);
        adv(16'd104, 16'hFFFF, 16'h7FFF);
        check_lit("unreach_new", 16'd102, 16'd0);
        adv(16'd102, 16'hFFFF, 16'h7FFF);
        check_lit("unreach_update", 16'd102, 16'd0);
        adv(16'd102, 16'd9, 16'h1000);
        check_lit("update_when_full", 16'd7, 16'd1);

        // Inputs wander with no strobe: outputs hold.
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b0, 16'(k * 17 + 3), 16'(k), 16'hC000, "idle_hold");
        check_lit("stable_no_strobe", 16'd7, 16'd1);

        // Heartbeat beats a simultaneous advertisement on that very edge.
        step(1'b1, 1'b1, 16'd9, 16'd1, 16'h4000, "hb_and_adv");
        check_lit("hb_wins_same_edge", 16'h0000, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "hb_settle");
        check_lit("table_empty", 16'h0000, 16'hFFFF);
        adv(16'd9, 16'd1, 16'h4000);
        check_lit("refill_after_hb", 16'd9, 16'd1);
        adv(16'd10, 16'd2, 16'h4000);

        // Asynchronous reset between edges clears outputs at once.
        #2;
        nrst = 1'b1;
        #1;
        model_clear();
        check_lit("async_reset", 16'h0000, 16'hFFFF);
        nrst = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "post_reset");
        check_lit("post_reset_empty", 16'h0000, 16'hFFFF);
        adv(16'd11, 16'd3, 16'h0001);
        check_lit("after_reset_adv", 16'd11, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/known_ch_v3.md
KNOWN_CH_V3 -- requirements
Module: known_ch_v3

Interface
- REQ-001 Parameter WORD_WIDTH, default 16, data width of all ID/hops/Q-value fields.
- REQ-002 Parameter KCH_DEPTH, default 8, number of known-cluster-head table entries.
- REQ-003 clk  input  1  sole clock; all state updates on rising edge.
- REQ-004 nrst  input  1  reset, asynchronous and active-high (port keeps the codebase name nrst; asserted = 1).
- REQ-005 en_KCH  input  1  single-cycle strobe: fCH_* carry a received cluster-head advertisement.
- REQ-006 HB_reset  input  1  heartbeat received; clears all known-CH state.
- REQ-007 fCH_ID  input  WORD_WIDTH  advertised cluster-head node ID.
- REQ-008 fCH_Hops  input  WORD_WIDTH  hop count to the advertised CH; 0xFFFF means unreachable.
- REQ-009 fCH_QValue  input  WORD_WIDTH  unsigned Q-value, fixed point Q2.14 (0x4000 = 1.00).
- REQ-010 chosenCH  output  WORD_WIDTH  ID of the currently selected cluster head, registered.
- REQ-011 hopsFromCH  output  WORD_WIDTH  hop count of chosenCH, registered.

Function
- REQ-012 Table holds KCH_DEPTH entries {valid, ID, hops, Q}, filled in arrival order from index 0.
- REQ-013 On an edge with en_KCH=1 and HB_reset=0: if fCH_ID matches a valid entry, that entry's hops/Q are overwritten in place; otherwise the advertisement goes into the lowest free index.
- REQ-014 Advertisement with fCH_Hops=0xFFFF is ignored; no table change.
- REQ-015 Table full and new ID not present: advertisement dropped, table unchanged.
- REQ-016 Best entry rule: lowest hops wins; equal hops, higher Q wins; equal hops and Q, higher table index (later arrival) wins.
- REQ-017 Best-entry selection is combinational over the table; chosenCH/hopsFromCH are registered from it every cycle, so outputs reflect an en_KCH edge one edge later (2-edge latency from strobe sample to output).
- REQ-018 No valid entries: chosenCH=0x0000, hopsFromCH=0xFFFF.
- REQ-019 HB_reset=1 on an edge clears all valid bits and forces outputs to 0x0000/0xFFFF on that same edge.
- REQ-020 HB_reset and en_KCH on the same edge: HB_reset wins; advertisement discarded.
- REQ-021 Q comparison is unsigned full-width; hops comparison is unsigned full-width; no arithmetic overflow paths.
- REQ-022 Outputs stay stable while inputs change with en_KCH=0.

Reset
- REQ-023 nrst=1 asynchronously clears all valid bits, chosenCH to 0x0000 and hopsFromCH to 0xFFFF; table ID/hops/Q contents also cleared to 0.
- REQ-024 Deassertion of nrst is synchronised externally; the block operates normally from the first edge after nrst=0.

Structure
- REQ-025 Package known_ch_pkg holds WORD_WIDTH, KCH_DEPTH defaults, HOPS_INVALID (0xFFFF) and the table entry struct type.
- REQ-026 One sub-module kch_best_select: combinational best-entry selector (REQ-016) returning valid/ID/hops; the top holds the table, the write logic and the output registers.

Verification
- REQ-027 Reset, then HB_reset pulse -> chosenCH=0x0000, hopsFromCH=0xFFFF.
- REQ-028 en_KCH with ID=23, hops=2, Q=0x3000 -> two edges later chosenCH=23, hopsFromCH=2; then ID=45, hops=2, Q=0x2000 -> chosenCH stays 23.
- REQ-029 Then ID=6, hops=1, Q=0x4000 -> chosenCH=6, hopsFromCH=1; then ID=7, hops=1, Q=0x4000 -> chosenCH=7 (tie, later wins); then ID=65, hops=1, Q=0x6000 -> chosenCH=65.
- REQ-030 Re-advertise ID=65 with hops=3 -> entry updated in place; chosenCH=7, hopsFromCH=1; no new entry consumed.
- REQ-031 Fill 8 distinct IDs, send 9th ID with hops=0 -> ignored, chosenCH unchanged; hops=0xFFFF advertisement -> ignored.
- REQ-032 HB_reset and en_KCH(ID=9, hops=1) on same edge -> outputs 0x0000/0xFFFF, table empty; nrst pulse asserted mid-sequence (between clock edges) -> outputs clear immediately.
